// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: EX-stage ALU operation decode plus MUL/DIV sequencer.
// Latency: Operation and Con_* are combinational. An MDU op holds the pipeline for LAT+1 cycles,
//   with done_o one cycle later. A divide with a zero divisor reports done_o in the next cycle.
// Backpressure: stall_o freezes IF/ID/EX from the start cycle through the last BUSY cycle.
//   flush_i aborts an in-flight op, and a synchronous reset drops it silently.
//
// Ports:
//   clk, rst_n            single clock; synchronous active-low reset
//   valid_i, flush_i      EX instruction present / kill it (and any in-flight MDU op)
//   ALUOp, Funct7, Funct3 main-decoder class and instruction function fields
//   Branch, Mem, OpI      branch / load-store / OP-IMM instruction flags
//   div0_i                divisor is zero (looked at only in the start cycle)
//   Operation             ALU/MDU operation select
//   Con_beq..Con_bgt      branch-condition selects
//   stall_o               pipeline freeze
//   mdu_start_o/abort_o   one-cycle launch / cancel pulses to the MDU
//   mdu_op_o              Funct3 captured at launch
//   done_o                MDU result valid and retiring
module alu_seq_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  // The counter must be able to hold max(MUL_LAT, DIV_LAT) - 1.
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       flush_i,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       Branch,
  input  logic       Mem,
  input  logic       OpI,
  input  logic       div0_i,
  output logic [4:0] Operation,
  output logic       Con_beq,
  output logic       Con_bnq,
  output logic       Con_blt,
  output logic       Con_bgt,
  output logic       stall_o,
  output logic       mdu_start_o,
  output logic [2:0] mdu_op_o,
  output logic       mdu_abort_o,
  output logic       done_o
);

  // ALU operation encodings
  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SLTU = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_BUNS = 5'b00111;  // unsigned compare for BLTU/BGEU
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01100;

  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // The counter is loaded with LAT-1 so that BUSY lasts exactly LAT cycles (LAT-1 down to 0).
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic is_rtype;
  logic is_mop;
  logic is_div;
  logic start;
  logic stall;
  logic abort;
  logic done;

  assign is_rtype = (ALUOp == 2'b10) & ~OpI;
  assign is_mop   = is_rtype & (Funct7 == F7_MEXT);
  assign is_div   = Funct3[2];

  // --------------------------------------------------------------------------
  // Operation decode. Priority: address generation, branch compare, M-extension,
  // then the shared R-type / OP-IMM Funct3 table.
  // --------------------------------------------------------------------------
  always_comb begin
    Operation = OP_ADD;
    if (Mem || (ALUOp == 2'b00 && !OpI)) begin
      Operation = OP_ADD;
    end else if (ALUOp == 2'b01) begin
      Operation = (Funct3[2:1] == 2'b11) ? OP_BUNS : OP_SUB;
    end else if (is_mop) begin
      Operation = {2'b10, Funct3};
    end else if (ALUOp == 2'b10 || OpI) begin
      unique case (Funct3)
        // An immediate has no subtract form, so Funct7 only matters for R-type here.
        3'b000:  Operation = (is_rtype && Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
        3'b001:  Operation = OP_SLL;
        3'b010:  Operation = OP_SLT;
        3'b011:  Operation = OP_SLTU;
        3'b100:  Operation = OP_XOR;
        // SRAI carries the same Funct7 pattern in imm[11:5], so no R-type qualifier applies.
        3'b101:  Operation = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
        3'b110:  Operation = OP_OR;
        default: Operation = OP_AND;
      endcase
    end
  end

  // Branch-condition selects: BLT/BLTU share one select, as do BGE/BGEU.
  always_comb begin
    Con_beq = Branch & valid_i & (Funct3 == 3'b000);
    Con_bnq = Branch & valid_i & (Funct3 == 3'b001);
    Con_blt = Branch & valid_i & Funct3[2] & ~Funct3[0];
    Con_bgt = Branch & valid_i & Funct3[2] &  Funct3[0];
  end

  // --------------------------------------------------------------------------
  // MDU sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    start   = 1'b0;
    stall   = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_i && is_mop && !flush_i) begin
          start = 1'b1;
          stall = 1'b1;
          op_d  = Funct3;
          if (is_div && div0_i) begin
            // The divide-by-zero result is fixed, so skip the iteration entirely.
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (flush_i) begin
          // The pipeline must move on this cycle, so the stall drops immediately.
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        // The EX instruction still present here is the one retiring, so it is never relaunched.
        if (flush_i) begin
          abort = 1'b1;
        end else begin
          done = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset is synchronous, so the pulses are gated directly. This keeps them quiet
  // from the first cycle of reset, before the state register has been cleared.
  assign stall_o     = rst_n & stall;
  assign mdu_start_o = rst_n & start;
  assign mdu_abort_o = rst_n & abort;
  assign done_o      = rst_n & done;
  assign mdu_op_o    = op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n, valid_i, flush_i, Branch, Mem, OpI, div0_i;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic [4:0] Operation;
  logic       Con_beq, Con_bnq, Con_blt, Con_bgt;
  logic       stall_o, mdu_start_o, mdu_abort_o, done_o;
  logic [2:0] mdu_op_o;

  alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .Branch(Branch), .Mem(Mem), .OpI(OpI), .div0_i(div0_i),
    .Operation(Operation),
    .Con_beq(Con_beq), .Con_bnq(Con_bnq), .Con_blt(Con_blt), .Con_bgt(Con_bgt),
    .stall_o(stall_o), .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o),
    .mdu_abort_o(mdu_abort_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstn;
    logic       valid;
    logic       flush;
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       br;
    logic       mem;
    logic       opi;
    logic       div0;
  } stim_t;

  // Expected per-cycle outputs
  typedef struct {
    logic [4:0] op;
    logic [3:0] con;
    logic       stall;
    logic       start;
    logic       abort;
  } ctl_t;

  // Expected retirement: cycle of done_o and the op it reports
  typedef struct {
    int         cyc;
    logic [2:0] op;
  } done_t;

  ctl_t  ctl_q[$];
  done_t done_q[$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: one MDU op in flight, retiring at m_end
  bit m_active = 1'b0;
  int m_end    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_m(input stim_t s);
    return s.aluop == 2'b10 && !s.opi && s.f7 == 7'h01;
  endfunction

  // Operation from the instruction tables, written as plain mnemonic lookups.
  function automatic logic [4:0] ref_op(input stim_t s);
    bit rtype = (s.aluop == 2'b10) && !s.opi;
    if (s.mem) return 5'b00010;
    if (s.aluop == 2'b00 && !s.opi) return 5'b00010;
    if (s.aluop == 2'b01) return (s.f3 == 3'd6 || s.f3 == 3'd7) ? 5'b00111 : 5'b00110;
    if (is_m(s)) return {2'b10, s.f3};
    if (!(rtype || s.opi)) return 5'b00010;
    case (s.f3)
      3'd0: return (rtype && s.f7 == 7'h20) ? 5'b00110 : 5'b00010;
      3'd1: return 5'b00100;
      3'd2: return 5'b01010;
      3'd3: return 5'b00101;
      3'd4: return 5'b00011;
      3'd5: return (s.f7 == 7'h20) ? 5'b01100 : 5'b01000;
      3'd6: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [3:0] ref_con(input stim_t s);
    logic [3:0] c;
    bit en = s.br && s.valid;
    c[3] = en && (s.f3 == 3'd0);
    c[2] = en && (s.f3 == 3'd1);
    c[1] = en && (s.f3 inside {3'd4, 3'd6});
    c[0] = en && (s.f3 inside {3'd5, 3'd7});
    return c;
  endfunction

  // Drive one cycle of stimulus and predict what the DUT must show in that cycle.
  task automatic step(input stim_t s);
    ctl_t e;
    int   lat;
    @(posedge clk);
    #1;
    rst_n = s.rstn;  valid_i = s.valid; flush_i = s.flush;
    ALUOp = s.aluop; Funct7 = s.f7;     Funct3 = s.f3;
    Branch = s.br;   Mem = s.mem;       OpI = s.opi;     div0_i = s.div0;
    e.op    = ref_op(s);
    e.con   = ref_con(s);
    e.stall = 1'b0;
    e.start = 1'b0;
    e.abort = 1'b0;
    if (!s.rstn) begin
      if (m_active) void'(done_q.pop_back());
      m_active = 1'b0;
    end else if (m_active) begin
      if (s.flush) begin
        e.abort = 1'b1;
        void'(done_q.pop_back());
        m_active = 1'b0;
      end else if (cyc == m_end) begin
        m_active = 1'b0;
      end else begin
        e.stall = 1'b1;
      end
    end else if (s.valid && is_m(s) && !s.flush) begin
      lat = !s.f3[2] ? MUL_LAT : (s.div0 ? 0 : DIV_LAT);
      e.start = 1'b1;
      e.stall = 1'b1;
      m_end = cyc + lat + 1;
      done_q.push_back('{cyc: m_end, op: s.f3});
      m_active = 1'b1;
    end
    ctl_q.push_back(e);
  endtask

  // Monitor: compares each cycle mid-period, independent of the driver.
  always @(negedge clk) begin
    ctl_t  e;
    done_t d;
    if (ctl_q.size() > 0) begin
      e = ctl_q.pop_front();
      chk("operation", 32'(Operation), 32'(e.op));
      chk("con", 32'({Con_beq, Con_bnq, Con_blt, Con_bgt}), 32'(e.con));
      chk("stall", 32'(stall_o), 32'(e.stall));
      chk("mdu_start", 32'(mdu_start_o), 32'(e.start));
      chk("mdu_abort", 32'(mdu_abort_o), 32'(e.abort));
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
        chk("done_op", 32'(mdu_op_o), 32'(d.op));
      end
    end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
      d = done_q.pop_front();
      chk("done_missing", 32'(done_o), 32'd1);
    end
  end

  function automatic stim_t nop();
    stim_t s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic stim_t mop(input logic [2:0] f3, input logic div0);
    stim_t s = nop();
    s.valid = 1'b1; s.aluop = 2'b10; s.f7 = 7'h01; s.f3 = f3; s.div0 = div0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rstn  = 1'b1;
    s.valid = ($urandom_range(3) != 0);
    s.flush = 1'b0;
    s.aluop = 2'($urandom_range(3));
    case ($urandom_range(3))
      0: s.f7 = 7'h00;
      1: s.f7 = 7'h20;
      2: s.f7 = 7'h01;
      default: s.f7 = 7'($urandom);
    endcase
    s.f3   = 3'($urandom_range(7));
    s.br   = 1'($urandom_range(1));
    s.mem  = 1'($urandom_range(1));
    s.opi  = 1'($urandom_range(1));
    s.div0 = ($urandom_range(3) == 0);
    if ($urandom_range(2) == 0) begin
      s.aluop = 2'b10; s.opi = 1'b0; s.f7 = 7'h01; s.mem = 1'b0;
    end
    // Keep Mem out of the M-op encoding; that combination is not a real instruction.
    if (s.mem && s.f7 == 7'h01) s.f7 = 7'h00;
    return s;
  endfunction

  initial begin
    stim_t s, prev;
    logic [6:0] f7v[4];
    f7v[0] = 7'h00; f7v[1] = 7'h20; f7v[2] = 7'h01; f7v[3] = 7'h40;

    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ALUOp = 2'b00; Funct7 = '0;
    Funct3 = '0; Branch = 1'b0; Mem = 1'b0; OpI = 1'b0; div0_i = 1'b0;

    // Reset, including an M-op presented while reset is low
    s = nop(); s.rstn = 1'b0;
    repeat (2) step(s);
    s = mop(3'd0, 1'b0); s.rstn = 1'b0;
    step(s);
    repeat (2) step(nop());

    // Decode sweep; flush suppresses any MDU start so every cycle is combinational only
    for (int a = 0; a < 4; a++)
      for (int o = 0; o < 2; o++)
        for (int m = 0; m < 2; m++)
          for (int b = 0; b < 2; b++)
            for (int f = 0; f < 8; f++)
              for (int k = 0; k < 4; k++) begin
                if (m == 1 && k == 2) continue;
                s = nop();
                s.valid = 1'b1; s.flush = 1'b1; s.aluop = 2'(a); s.opi = 1'(o);
                s.mem = 1'(m); s.br = 1'(b); s.f3 = 3'(f); s.f7 = f7v[k];
                step(s);
              end
    step(nop());

    // MUL, held through the stall
    repeat (MUL_LAT + 1) step(mop(3'd0, 1'b0));
    repeat (2) step(nop());

    // DIVU, normal and divide-by-zero
    repeat (DIV_LAT + 1) step(mop(3'd5, 1'b0));
    repeat (2) step(nop());
    step(mop(3'd5, 1'b1));
    repeat (2) step(nop());

    // DIV flushed in its fifth BUSY cycle, then an ADD with no stall
    repeat (5) step(mop(3'd4, 1'b0));
    s = mop(3'd4, 1'b0); s.flush = 1'b1;
    step(s);
    s = nop(); s.valid = 1'b1; s.aluop = 2'b10;
    repeat (3) step(s);

    // Reset in the tenth BUSY cycle of a DIV, then a MUL with its full latency
    repeat (10) step(mop(3'd4, 1'b0));
    s = mop(3'd4, 1'b0); s.rstn = 1'b0;
    step(s);
    repeat (MUL_LAT + 1) step(mop(3'd0, 1'b0));
    repeat (2) step(nop());

    // MUL then REM back to back; REM is already present in the MUL's DONE cycle
    repeat (MUL_LAT + 1) step(mop(3'd0, 1'b0));
    repeat (DIV_LAT + 2) step(mop(3'd6, 1'b0));
    repeat (2) step(nop());

    // Flush landing in the DONE cycle
    repeat (MUL_LAT + 1) step(mop(3'd1, 1'b0));
    s = mop(3'd1, 1'b0); s.flush = 1'b1;
    step(s);
    repeat (2) step(nop());

    // Randomized traffic; stalled instructions are usually held as a pipeline would
    prev = nop();
    for (int i = 0; i < 3000; i++) begin
      s = (m_active && $urandom_range(3) != 0) ? prev : rand_stim();
      s.flush = ($urandom_range(15) == 0);
      s.rstn  = ($urandom_range(199) != 0);
      step(s);
      prev = s;
    end

    repeat (DIV_LAT + 4) step(nop());
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_done", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
